matrix_rx: RTL and testbench

Receive-side model of the LED matrix panel driver. Samples the serial panel interface (sclk, sdata, lat, blank, disp_row) produced by the sequencer, shifts column data into a 32-column line register, and commits the line into an 8-row on-chip frame buffer on each latch pulse. It sits on the far end of the panel cable, both in the self-check bench and in the loopback test build. It exposes a registered frame-buffer read port and framing/error status.

---
 rtl/matrix_pkg.sv | 34 +++
 rtl/edge_sync.sv | 55 +++++
 rtl/matrix_rx.sv | 179 +++++++++++++++++
 tb/tb_matrix_rx.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matrix_pkg
// Description : Shared sizes, types and receive-FSM encoding for the LED
//               matrix panel receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package matrix_pkg;

    localparam int NUM_COLS = 32;
    localparam int NUM_ROWS = 8;
    localparam int PIX_W    = 3;

    localparam int ROW_W    = $clog2(NUM_ROWS);
    localparam int COL_W    = $clog2(NUM_COLS);
    localparam int CNT_W    = 6;

    // Bit counter saturates here so an over-long line can never wrap
    // around to look like a correct one.
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    typedef logic [ROW_W-1:0]                 row_t;
    typedef logic [COL_W-1:0]                 col_t;
    typedef logic [PIX_W-1:0]                 pix_t;
    typedef logic [NUM_COLS-1:0][PIX_W-1:0]   line_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : edge_sync
// Description : Two-flop synchronizer with an optional third flop providing
//               a one-cycle rising-edge pulse per bit.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_sync #(
    parameter int WIDTH = 1,
    parameter bit EDGE  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    // Two-stage metastability filter on the asynchronous input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

    generate
        if (EDGE) begin : g_edge
            logic [WIDTH-1:0] r_s3;

            // Delayed copy for rising-edge detection
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s3 <= '0;
                end else begin
                    r_s3 <= r_s2;
                end
            end

            assign o_rise = r_s2 & ~r_s3;
        end else begin : g_level
            assign o_rise = '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/matrix_rx.sv
`default_nettype none
// ============================================================================
// Module      : matrix_rx
// Description : Receive side of the LED matrix panel link. Shifts serial
//               column data into a line register and commits it into an
//               on-chip frame buffer on each latch pulse; provides a
//               registered read port plus framing/error status.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_rx
    import matrix_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic [PIX_W-1:0] sdata,
    input  logic             lat,
    input  logic             blank,
    input  logic [ROW_W-1:0] disp_row,
    input  logic [ROW_W-1:0] rd_row,
    input  logic [COL_W-1:0] rd_col,
    output logic [PIX_W-1:0] rd_pix,
    output logic             row_wr,
    output logic [ROW_W-1:0] row_idx,
    output logic             line_err,
    output logic             frame_done,
    output logic             blank_s
);

    logic             w_sclk_rise;
    logic             w_lat_rise;
    pix_t             w_sdata_s;
    row_t             w_disp_row_s;

    logic             w_unused_sclk_lvl;
    logic             w_unused_lat_lvl;
    logic             w_unused_blank_rise;
    pix_t             w_unused_sdata_rise;
    row_t             w_unused_row_rise;

    rx_state_t        r_state;
    rx_state_t        w_state_nxt;
    logic             w_commit;

    line_t            r_line;
    logic [CNT_W-1:0] r_bitcnt;
    line_t            r_fb [NUM_ROWS];

    edge_sync #(.WIDTH(1), .EDGE(1'b1)) u_sync_sclk (
        .clk    (clk),
        .rst    (rst),
        .i_d    (sclk),
        .o_q    (w_unused_sclk_lvl),
        .o_rise (w_sclk_rise)
    );

    edge_sync #(.WIDTH(1), .EDGE(1'b1)) u_sync_lat (
        .clk    (clk),
        .rst    (rst),
        .i_d    (lat),
        .o_q    (w_unused_lat_lvl),
        .o_rise (w_lat_rise)
    );

    edge_sync #(.WIDTH(1), .EDGE(1'b0)) u_sync_blank (
        .clk    (clk),
        .rst    (rst),
        .i_d    (blank),
        .o_q    (blank_s),
        .o_rise (w_unused_blank_rise)
    );

    edge_sync #(.WIDTH(PIX_W), .EDGE(1'b0)) u_sync_sdata (
        .clk    (clk),
        .rst    (rst),
        .i_d    (sdata),
        .o_q    (w_sdata_s),
        .o_rise (w_unused_sdata_rise)
    );

    edge_sync #(.WIDTH(ROW_W), .EDGE(1'b0)) u_sync_row (
        .clk    (clk),
        .rst    (rst),
        .i_d    (disp_row),
        .o_q    (w_disp_row_s),
        .o_rise (w_unused_row_rise)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: first shift clock starts a line, latch commits, commit lasts one cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_sclk_rise) w_state_nxt = S_SHIFT;
            S_SHIFT:  if (w_lat_rise)  w_state_nxt = S_COMMIT;
            S_COMMIT: w_state_nxt = S_SHIFT;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: commit strobe for datapath and status
    always_comb begin
        w_commit = 1'b0;
        if (r_state == S_COMMIT) begin
            w_commit = 1'b1;
        end
    end

    // Line register: newest pixel enters column 0, older pixels move up.
    // Shifting is allowed in every state, so a shift clock during the commit
    // cycle lands in the next line while the old contents are written out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line <= '0;
        end else if (w_sclk_rise) begin
            r_line <= {r_line[NUM_COLS-2:0], w_sdata_s};
        end
    end

    // Per-line bit counter, saturating; restarts at commit (counting a coincident shift)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bitcnt <= '0;
        end else if (w_commit) begin
            r_bitcnt <= w_sclk_rise ? CNT_W'(1) : '0;
        end else if (w_sclk_rise && (r_bitcnt != c_cnt_max)) begin
            r_bitcnt <= r_bitcnt + CNT_W'(1);
        end
    end

    // Frame buffer write on commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ROWS; i++) begin
                r_fb[i] <= '0;
            end
        end else if (w_commit) begin
            r_fb[w_disp_row_s] <= r_line;
        end
    end

    // Commit status: pulses, last row index and sticky length error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_wr     <= 1'b0;
            frame_done <= 1'b0;
            row_idx    <= '0;
            line_err   <= 1'b0;
        end else begin
            row_wr     <= w_commit;
            frame_done <= w_commit && (w_disp_row_s == row_t'(NUM_ROWS - 1));
            if (w_commit) begin
                row_idx <= w_disp_row_s;
                if (r_bitcnt != CNT_W'(NUM_COLS)) begin
                    line_err <= 1'b1;
                end
            end
        end
    end

    // Registered frame-buffer read port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pix <= '0;
        end else begin
            rd_pix <= r_fb[rd_row][rd_col];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_rx
// Description : Self-checking bench for matrix_rx: a table of line/latch
//               records, hand-written corner sequences and randomized lines,
//               all compared against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_rx;
    import matrix_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic [2:0] sdata = '0;
    logic       lat = 1'b0;
    logic       blank = 1'b0;
    logic [2:0] disp_row = '0;
    logic [2:0] rd_row = '0;
    logic [4:0] rd_col = '0;
    logic [2:0] rd_pix;
    logic       row_wr;
    logic [2:0] row_idx;
    logic       line_err;
    logic       frame_done;
    logic       blank_s;

    always #5 clk = ~clk;

    matrix_rx dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .sdata      (sdata),
        .lat        (lat),
        .blank      (blank),
        .disp_row   (disp_row),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_pix     (rd_pix),
        .row_wr     (row_wr),
        .row_idx    (row_idx),
        .line_err   (line_err),
        .frame_done (frame_done),
        .blank_s    (blank_s)
    );

    typedef struct {
        int   nbits;
        int   row;
        logic exp_err;
        int   exp_fd;
    } vec_t;

    vec_t tbl [13];

    int vectors    = 0;
    int miscompares = 0;

    // Pulse counters sampled on the falling edge
    int wr_cnt = 0;
    int fd_cnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            wr_cnt = 0;
            fd_cnt = 0;
        end else begin
            if (row_wr === 1'b1)     wr_cnt++;
            if (frame_done === 1'b1) fd_cnt++;
        end
    end

    // Reference model: every pixel shifted since reset (last 32 kept).
    // Column c of a committed line is the c-th most recent pixel; columns
    // never reached since reset still hold zero.
    logic [2:0] m_q [$];
    int         m_cnt;
    bit         m_active;
    logic       m_err;
    logic [2:0] m_fb [8][32];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cnt    = 0;
        m_active = 1'b0;
        m_err    = 1'b0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 32; c++)
                m_fb[r][c] = 3'd0;
    endtask

    task automatic model_bit(input logic [2:0] d);
        m_q.push_back(d);
        if (m_q.size() > 32) m_q.delete(0);
        m_active = 1'b1;
        if (m_cnt < 63) m_cnt++;
    endtask

    task automatic model_commit(input int row);
        if (m_active) begin
            for (int c = 0; c < 32; c++)
                m_fb[row][c] = (c < m_q.size()) ? m_q[m_q.size() - 1 - c] : 3'd0;
            if (m_cnt != 32) m_err = 1'b1;
            m_cnt = 0;
        end
    endtask

    // One serial pixel: data set up 2 clk before the rise, held 6 clk after
    task automatic send_bit(input logic [2:0] d);
        sdata = d;
        tick(2);
        sclk = 1'b1;
        model_bit(d);
        tick(4);
        sclk = 1'b0;
        tick(2);
    endtask

    task automatic send_random(input int n);
        for (int i = 0; i < n; i++) send_bit(3'($urandom_range(0, 7)));
    endtask

    task automatic latch(input int row);
        disp_row = 3'(row);
        tick(2);
        lat = 1'b1;
        model_commit(row);
        tick(4);
        lat = 1'b0;
        tick(4);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        model_reset();
        tick(2);
    endtask

    task automatic check_row(input int row);
        for (int c = 0; c < 32; c++) begin
            rd_row = 3'(row);
            rd_col = 5'(c);
            tick(1);
            check($sformatf("pix r%0d c%0d", row, c), 32'(rd_pix), 32'(m_fb[row][c]));
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         fd_before;
        int         wr_before;
        logic [2:0] d;
        int         n;
        int         r;

        // {bits shifted, latched row, line_err after, frame_done pulses}
        tbl[0]  = '{32, 0, 1'b0, 0};
        tbl[1]  = '{32, 1, 1'b0, 0};
        tbl[2]  = '{32, 2, 1'b0, 0};
        tbl[3]  = '{32, 3, 1'b0, 0};
        tbl[4]  = '{32, 4, 1'b0, 0};
        tbl[5]  = '{32, 5, 1'b0, 0};
        tbl[6]  = '{32, 6, 1'b0, 0};
        tbl[7]  = '{32, 7, 1'b0, 1};
        tbl[8]  = '{31, 2, 1'b1, 0};
        tbl[9]  = '{32, 4, 1'b1, 0};
        tbl[10] = '{40, 5, 1'b1, 0};
        tbl[11] = '{70, 6, 1'b1, 0};
        tbl[12] = '{32, 7, 1'b1, 1};

        // Reset state
        tick(3);
        rst = 1'b0;
        model_reset();
        tick(1);
        check("reset rd_pix", 32'(rd_pix), 0);
        check("reset row_wr", 32'(row_wr), 0);
        check("reset row_idx", 32'(row_idx), 0);
        check("reset line_err", 32'(line_err), 0);
        check("reset frame_done", 32'(frame_done), 0);
        check("reset blank_s", 32'(blank_s), 0);

        // blank is only reported through its synchronizer
        blank = 1'b1;
        tick(3);
        check("blank_s high", 32'(blank_s), 1);
        blank = 1'b0;
        tick(3);
        check("blank_s low", 32'(blank_s), 0);

        // Column ordering and latch-to-row_wr latency
        for (int i = 0; i < 32; i++) send_bit(3'(i % 8));
        disp_row = 3'd3;
        tick(2);
        lat = 1'b1;
        model_commit(3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("row_wr before lat+4", 32'(row_wr), 0);
        @(posedge clk);
        @(negedge clk);
        check("row_wr at lat+4", 32'(row_wr), 1);
        check("row_idx at lat+4", 32'(row_idx), 3);
        @(posedge clk);
        @(negedge clk);
        check("row_wr after lat+4", 32'(row_wr), 0);
        @(posedge clk);
        #1;
        lat = 1'b0;
        tick(3);
        check("ordering line_err", 32'(line_err), 0);
        for (int c = 0; c < 32; c++) begin
            rd_row = 3'd3;
            rd_col = 5'(c);
            tick(1);
            check($sformatf("order c%0d", c), 32'(rd_pix), 32'((31 - c) % 8));
        end

        // Table-driven lines: full frame, then short/long/saturating lines
        do_reset();
        for (int i = 0; i < 13; i++) begin
            fd_before = fd_cnt;
            wr_before = wr_cnt;
            send_random(tbl[i].nbits);
            latch(tbl[i].row);
            check($sformatf("tbl%0d row_wr", i), 32'(wr_cnt - wr_before), 1);
            check($sformatf("tbl%0d row_idx", i), 32'(row_idx), 32'(tbl[i].row));
            check($sformatf("tbl%0d line_err", i), 32'(line_err), 32'(tbl[i].exp_err));
            check($sformatf("tbl%0d frame_done", i), 32'(fd_cnt - fd_before), 32'(tbl[i].exp_fd));
            check_row(tbl[i].row);
            if (i == 7) begin
                for (int rr = 0; rr < 8; rr++) check_row(rr);
            end
        end

        // Reset mid-line clears everything immediately
        send_random(16);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst line_err", 32'(line_err), 0);
        check("midrst row_idx", 32'(row_idx), 0);
        check("midrst rd_pix", 32'(rd_pix), 0);
        tick(2);
        rst = 1'b0;
        model_reset();
        tick(2);
        check_row(5);
        check_row(6);
        send_random(32);
        latch(5);
        check("after midrst line_err", 32'(line_err), 0);
        check_row(5);

        // sclk and lat rising together: the bit belongs to the committed line
        do_reset();
        send_random(31);
        d = 3'($urandom_range(0, 7));
        sdata = d;
        disp_row = 3'd1;
        tick(2);
        sclk = 1'b1;
        lat = 1'b1;
        model_bit(d);
        model_commit(1);
        tick(4);
        sclk = 1'b0;
        lat = 1'b0;
        tick(4);
        check("coincident line_err", 32'(line_err), 0);
        check_row(1);

        // sclk during the commit cycle: the bit starts the next line
        send_random(32);
        d = 3'($urandom_range(0, 7));
        sdata = d;
        disp_row = 3'd2;
        tick(2);
        lat = 1'b1;
        model_commit(2);
        tick(1);
        sclk = 1'b1;
        model_bit(d);
        tick(4);
        sclk = 1'b0;
        lat = 1'b0;
        tick(4);
        check("commit-cycle line_err", 32'(line_err), 0);
        check_row(2);
        send_random(31);
        latch(4);
        check("next line line_err", 32'(line_err), 0);
        check_row(4);

        // Randomized lines against the model
        do_reset();
        for (int k = 0; k < 12; k++) begin
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(28, 36) : 32;
            r = $urandom_range(0, 7);
            fd_before = fd_cnt;
            send_random(n);
            latch(r);
            check($sformatf("rnd%0d row_idx", k), 32'(row_idx), 32'(r));
            check($sformatf("rnd%0d line_err", k), 32'(line_err), 32'(m_err));
            check($sformatf("rnd%0d frame_done", k), 32'(fd_cnt - fd_before), (r == 7) ? 1 : 0);
            check_row(r);
        end
        for (int rr = 0; rr < 8; rr++) check_row(rr);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
